// File: rtl/hci_mem_bank_target.sv
// Single-port HCI memory bank target: byte-enabled writes, fixed-latency in-order responses.
// Optional pseudo-random grant stall enabled by defining HCI_MEM_BANK_TARGET_STALL_EN.
module hci_mem_bank_target #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned BW      = 8,
  parameter int unsigned IW      = 20,
  parameter int unsigned N_WORDS = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [AW-1:0]    add_i,
  input  logic             wen_i,
  input  logic [DW/BW-1:0] be_i,
  input  logic [DW-1:0]    data_i,
  input  logic [IW-1:0]    id_i,
  output logic             r_valid_o,
  output logic [DW-1:0]    r_data_o,
  output logic [IW-1:0]    r_id_o,
  output logic [31:0]      rd_cnt_o,
  output logic [31:0]      wr_cnt_o,
  input  logic             cnt_clear_i
);

  localparam int unsigned NB   = DW / BW;
  localparam int unsigned OFF  = $clog2(DW / 8);
  localparam int unsigned IDXW = $clog2(N_WORDS);

  // Handshake: a request is accepted on the rising edge where req_i & gnt_o;
  // the response side has no ready and every accept yields one response.
  logic                accept;
  logic                rd_acc;
  logic                wr_acc;
  logic                stall;
  logic [IDXW-1:0]     idx;
  logic [DW-1:0]       mem_q [N_WORDS];

  logic                pipe_valid_q [LATENCY];
  logic [IW-1:0]       pipe_id_q    [LATENCY];
  logic [DW-1:0]       pipe_data_q  [LATENCY];

  logic                unused_add;

  assign idx        = add_i[OFF+IDXW-1:OFF];
  assign unused_add = ^{add_i[AW-1:OFF+IDXW], add_i[OFF-1:0]};

`ifdef HCI_MEM_BANK_TARGET_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11 in right-shift form.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign stall   = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`else
  assign stall = 1'b0;
`endif

  assign gnt_o  = rst_ni & ~stall;
  assign accept = req_i & gnt_o;
  assign rd_acc = accept & wen_i;
  assign wr_acc = accept & ~wen_i;

  // The array has no reset; gnt_o is low in reset so no write lands then.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[idx][b*BW +: BW] <= data_i[b*BW +: BW];
        end
      end
    end
  end

  // ID/data of a stage only move with a valid token, so the last stage holds
  // the most recent response while r_valid_o is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_valid_q[s] <= 1'b0;
        pipe_id_q[s]    <= '0;
        pipe_data_q[s]  <= '0;
      end
    end else begin
      pipe_valid_q[0] <= accept;
      if (accept) begin
        pipe_id_q[0]   <= id_i;
        pipe_data_q[0] <= wen_i ? mem_q[idx] : '0;
      end
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid_q[s] <= pipe_valid_q[s-1];
        if (pipe_valid_q[s-1]) begin
          pipe_id_q[s]   <= pipe_id_q[s-1];
          pipe_data_q[s] <= pipe_data_q[s-1];
        end
      end
    end
  end

  assign r_valid_o = pipe_valid_q[LATENCY-1];
  assign r_id_o    = pipe_id_q[LATENCY-1];
  assign r_data_o  = pipe_data_q[LATENCY-1];

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || cnt_clear_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (rd_acc && (rd_cnt_o != 32'hFFFF_FFFF)) begin
        rd_cnt_o <= rd_cnt_o + 32'd1;
      end
      if (wr_acc && (wr_cnt_o != 32'hFFFF_FFFF)) begin
        wr_cnt_o <= wr_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hci_mem_bank_target.sv
// Bench for hci_mem_bank_target: LATENCY=1 and LATENCY=3 instances on shared stimulus,
// checked against a word-level memory model with per-cycle response schedules.
module tb_hci_mem_bank_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wen, clr;
  logic [31:0] add, data;
  logic [3:0]  be;
  logic [19:0] id;

  logic        gnt1, rv1, gnt3, rv3;
  logic [31:0] rdat1, rdat3, rc1, wc1, rc3, wc3;
  logic [19:0] rid1, rid3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hci_mem_bank_target #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .add_i(add), .wen_i(wen),
    .be_i(be), .data_i(data), .id_i(id), .r_valid_o(rv1), .r_data_o(rdat1), .r_id_o(rid1),
    .rd_cnt_o(rc1), .wr_cnt_o(wc1), .cnt_clear_i(clr)
  );

  hci_mem_bank_target #(.LATENCY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt3), .add_i(add), .wen_i(wen),
    .be_i(be), .data_i(data), .id_i(id), .r_valid_o(rv3), .r_data_o(rdat3), .r_id_o(rid3),
    .rd_cnt_o(rc3), .wr_cnt_o(wc3), .cnt_clear_i(clr)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [19:0] id;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mem_m [int];
  resp_t       due1 [int];
  resp_t       due3 [int];
  resp_t       last1, last3;
  int          cyc = 0;
  logic [31:0] m_rd, m_wr;
  logic [15:0] m_lfsr = 16'hACE1;
  int          resp_seen1 = 0;
  int          resp_seen3 = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic bit model_gnt();
`ifdef HCI_MEM_BANK_TARGET_STALL_EN
    return rst_n && (m_lfsr % 4 != 0);
`else
    return rst_n;
`endif
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    int bitv;
    bitv = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return 16'((l >> 1) | (bitv << 15));
  endfunction

  // One clock: apply inputs at negedge, advance model at posedge, check at next negedge.
  task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [19:0] i, input bit c, output bit acc);
    bit    g, v1, v3;
    int    idx;
    resp_t rsp;
    req = r; wen = w; add = a; be = b; data = d; id = i; clr = c;
    #1;
    g = model_gnt();
    check("gnt1", gnt1, g);
    check("gnt3", gnt3, g);
    acc = r && g;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      due1.delete(); due3.delete();
      m_rd = 0; m_wr = 0; last1 = '0; last3 = '0; m_lfsr = 16'hACE1;
    end else begin
      if (c) begin
        m_rd = 0; m_wr = 0;
      end else if (acc && w) begin
        if (m_rd != 32'hFFFF_FFFF) m_rd++;
      end else if (acc) begin
        if (m_wr != 32'hFFFF_FFFF) m_wr++;
      end
      if (acc) begin
        idx = int'((a / 4) % 1024);
        rsp.id = i;
        if (w) begin
          rsp.data = mem_m[idx];
        end else begin
          rsp.data = '0;
          if (!mem_m.exists(idx)) mem_m[idx] = 'x;
          for (int k = 0; k < 4; k++)
            if (b[k]) mem_m[idx][8*k +: 8] = d[8*k +: 8];
        end
        due1[cyc]     = rsp;
        due3[cyc + 2] = rsp;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    @(negedge clk);
    v1 = due1.exists(cyc);
    if (v1) begin last1 = due1[cyc]; due1.delete(cyc); end
    v3 = due3.exists(cyc);
    if (v3) begin last3 = due3[cyc]; due3.delete(cyc); end
    check("r_valid1", rv1, v1);
    check("r_id1", rid1, last1.id);
    check("r_data1", rdat1, last1.data);
    check("r_valid3", rv3, v3);
    check("r_id3", rid3, last3.id);
    check("r_data3", rdat3, last3.data);
    check("rd_cnt1", rc1, m_rd);
    check("wr_cnt1", wc1, m_wr);
    check("rd_cnt3", rc3, m_rd);
    check("wr_cnt3", wc3, m_wr);
    if (rv1 === 1'b1) resp_seen1++;
    if (rv3 === 1'b1) resp_seen3++;
  endtask

  // Retries a request until granted, bounded.
  task automatic drive_g(input bit w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [19:0] i, input bit c);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) drive(1'b1, w, a, b, d, i, c, acc);
    if (!acc) check("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, acc);
  endtask

  function automatic logic [31:0] region_addr(input int w);
    return ($urandom() & 32'hFFFF_F000) | 32'(w << 2) | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] data;
    logic [19:0] id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          grants;
    logic        obs_v  [7];
    logic [19:0] obs_id [7];
    logic        exp_v  [7];
    logic [19:0] exp_id [7];

    vecs[0] = '{1'b0, 32'h40,   4'hF, 32'hDEADBEEF, 20'd5,  32'h0};
    vecs[1] = '{1'b1, 32'h40,   4'h0, 32'h0,        20'd9,  32'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h80,   4'hF, 32'h11223344, 20'd6,  32'h0};
    vecs[3] = '{1'b0, 32'h80,   4'h5, 32'hAABBCCDD, 20'd7,  32'h0};
    vecs[4] = '{1'b1, 32'h80,   4'h0, 32'h0,        20'd8,  32'h11BB33DD};
    vecs[5] = '{1'b0, 32'h1000, 4'hF, 32'h5,        20'd10, 32'h0};
    vecs[6] = '{1'b1, 32'h0,    4'h0, 32'h0,        20'd11, 32'h5};

    rst_n = 1'b0;
    req = 0; wen = 0; add = '0; be = '0; data = '0; id = '0; clr = 0;
    idle(3);
    rst_n = 1'b1;

    // Known contents for words 0..15 used by random traffic.
    for (int w = 0; w < 16; w++) drive_g(1'b0, 32'(w * 4), 4'hF, $urandom(), 20'(w), 1'b0);

    for (int k = 0; k < 7; k++) begin
      drive_g(vecs[k].wen, vecs[k].add, vecs[k].be, vecs[k].data, vecs[k].id, 1'b0);
      check("tbl_valid", rv1, 1'b1);
      check("tbl_id", rid1, vecs[k].id);
      check("tbl_data", rdat1, vecs[k].exp_data);
    end

    // Sustained traffic with req held high.
    idle(1);
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, acc);
    resp_seen1 = 0;
    grants = 0;
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), region_addr($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom(), 20'($urandom()), 1'b0, acc);
      if (acc) grants++;
    end
    idle(4);
    check("resp_count", 64'(resp_seen1), 64'(grants));
    check("cnt_sum", 64'(rc1) + 64'(wc1), 64'(grants));

`ifndef HCI_MEM_BANK_TARGET_STALL_EN
    // Four back-to-back reads on the LATENCY=3 instance.
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, acc);
    exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_id = '{20'd0, 20'd0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd0};
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(1'b1, 1'b1, region_addr(k), 4'h0, '0, 20'(k + 1), 1'b0, acc);
      else       idle(1);
      obs_v[k]  = rv3;
      obs_id[k] = rid3;
    end
    for (int k = 0; k < 7; k++) begin
      check("lat3_valid", obs_v[k], exp_v[k]);
      if (exp_v[k]) check("lat3_id", obs_id[k], exp_id[k]);
    end
    check("lat3_rd_cnt", rc3, 32'd4);
`endif

    // Reset with two reads in flight; the write during reset must not land.
    drive_g(1'b1, 32'h4, 4'h0, '0, 20'd21, 1'b0);
    drive_g(1'b1, 32'h8, 4'h0, '0, 20'd22, 1'b0);
    resp_seen3 = 0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h12345678, 20'd23, 1'b0, acc);
    rst_n = 1'b1;
    idle(4);
    check("flight_valid", 64'(resp_seen3), 64'd0);
    check("rst_rd_cnt", rc3, 32'd0);
    check("rst_wr_cnt", wc3, 32'd0);
    drive_g(1'b1, 32'h40, 4'h0, '0, 20'd30, 1'b0);
    check("rst_no_write", rdat1, 32'hDEADBEEF);

    // Clear in the same cycle as an accepted write.
    drive_g(1'b0, 32'h44, 4'hF, 32'hCAFEF00D, 20'd31, 1'b0);
    check("wr_cnt_pre", wc1, 32'd1);
    drive_g(1'b0, 32'h44, 4'hF, 32'h0BADCAFE, 20'd32, 1'b1);
    check("clr_wr_cnt", wc1, 32'd0);
    drive_g(1'b1, 32'h44, 4'h0, '0, 20'd33, 1'b0);
    check("clr_write_done", rdat1, 32'h0BADCAFE);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
